// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//   SPI master shift engine. Takes a start request plus TX word, frame length,
//   CPOL/CPHA mode and SCLK divider from the register block. It runs one
//   chip-selected frame (LEAD, SHIFT, TRAIL) and returns the received word, a
//   busy flag and a one-cycle done pulse. Frames are sent MSB-first and can be
//   1..DATA_WIDE bits long.
//
//   Optional build macro:
//     SPI_SHIFT_LOOPBACK_EN - the RX shifter samples the internal MOSI bit
//                             instead of spi_miso_i. All pins still toggle.
//
//   Ports:
//     pclk_i      system clock
//     prstn_i     asynchronous active-low reset
//     start_i     single-cycle transfer request (accepted while idle)
//     tx_data_i   transmit word, bits [len_i:0] are sent
//     len_i       frame length minus one
//     cpol_i      SCLK idle level
//     cpha_i      0: sample on leading edge, 1: sample on trailing edge
//     clk_div_i   SCLK half-period minus one, in pclk cycles
//     busy_o      transfer in progress
//     done_o      one-cycle completion pulse
//     rx_data_o   received word, right-aligned, upper bits zero
//     spi_sclk_o  serial clock
//     spi_cs_n_o  chip select, active low
//     spi_mosi_o  serial data out
//     spi_miso_i  serial data in
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int DATA_WIDE = 32,
    parameter int DIV_WIDE  = 8,
    parameter int LEN_WIDE  = 5
) (
    input  logic                 pclk_i,
    input  logic                 prstn_i,
    input  logic                 start_i,
    input  logic [DATA_WIDE-1:0] tx_data_i,
    input  logic [LEN_WIDE-1:0]  len_i,
    input  logic                 cpol_i,
    input  logic                 cpha_i,
    input  logic [DIV_WIDE-1:0]  clk_div_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [DATA_WIDE-1:0] rx_data_o,
    output logic                 spi_sclk_o,
    output logic                 spi_cs_n_o,
    output logic                 spi_mosi_o,
    input  logic                 spi_miso_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } state_t;

    localparam logic [LEN_WIDE-1:0] LP_MAX_LEN = LEN_WIDE'(DATA_WIDE - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DATA_WIDE-1:0]   r_tx;
    logic [DATA_WIDE-1:0]   r_rx;
    logic [DATA_WIDE-1:0]   r_rx_data;
    logic [LEN_WIDE-1:0]    r_len;
    logic [DIV_WIDE-1:0]    r_div;
    logic [DIV_WIDE-1:0]    r_div_cnt;
    logic [LEN_WIDE:0]      r_edge_cnt;
    logic                   r_cpol;
    logic                   r_cpha;
    logic                   r_sclk;
    logic                   r_mosi;
    logic                   r_done;

    logic                   w_tick;
    logic                   w_last_edge;
    logic                   w_sample;
    logic                   w_drive;
    logic                   w_miso;
    logic [LEN_WIDE-1:0]    w_shamt;
    logic [DATA_WIDE-1:0]   w_tx_aligned;

`ifdef SPI_SHIFT_LOOPBACK_EN
    logic                   w_unused_miso;
    assign w_unused_miso = spi_miso_i;
    assign w_miso        = r_mosi;
`else
    assign w_miso        = spi_miso_i;
`endif

    // Divider compares against the latched value, so H = r_div+1 never overflows.
    assign w_tick       = (r_div_cnt == r_div);
    // Edge 2N-1 (0-based) is the final edge: {len,1} == 2*len+1.
    assign w_last_edge  = (r_edge_cnt == {r_len, 1'b1});
    // Left-align the frame so the MSB of the frame always leaves from the top bit.
    assign w_shamt      = LP_MAX_LEN - len_i;
    assign w_tx_aligned = tx_data_i << w_shamt;

    // State register
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start_i)               w_state_nxt = ST_LEAD;
            ST_LEAD:  if (w_tick)                w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_tick && w_last_edge) w_state_nxt = ST_TRAIL;
            ST_TRAIL: if (w_tick)                w_state_nxt = ST_IDLE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        busy_o     = (r_state != ST_IDLE);
        spi_cs_n_o = (r_state == ST_IDLE);
        w_sample   = 1'b0;
        w_drive    = 1'b0;
        if (r_state == ST_SHIFT && w_tick) begin
            // Even 0-based edge index = leading edge. CPHA selects which
            // parity samples; the other parity drives, except the last edge.
            w_sample = (r_edge_cnt[0] == r_cpha);
            w_drive  = (r_edge_cnt[0] != r_cpha) && !w_last_edge;
        end
    end

    assign done_o     = r_done;
    assign rx_data_o  = r_rx_data;
    assign spi_sclk_o = r_sclk;
    assign spi_mosi_o = r_mosi;

    // Datapath
    always_ff @(posedge pclk_i or negedge prstn_i) begin
        if (!prstn_i) begin
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_len      <= '0;
            r_div      <= '0;
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= cpol_i;
                    if (start_i) begin
                        r_len      <= len_i;
                        r_cpol     <= cpol_i;
                        r_cpha     <= cpha_i;
                        r_div      <= clk_div_i;
                        r_div_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_rx       <= '0;
                        // CPHA=0 presents the first bit during LEAD, so it is
                        // moved to MOSI now and the shifter starts one bit on.
                        if (cpha_i) begin
                            r_tx   <= w_tx_aligned;
                            r_mosi <= 1'b0;
                        end else begin
                            r_tx   <= {w_tx_aligned[DATA_WIDE-2:0], 1'b0};
                            r_mosi <= w_tx_aligned[DATA_WIDE-1];
                        end
                    end
                end
                ST_LEAD: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                end
                ST_SHIFT: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                    if (w_sample) begin
                        r_rx <= {r_rx[DATA_WIDE-2:0], w_miso};
                    end
                    if (w_drive) begin
                        r_mosi <= r_tx[DATA_WIDE-1];
                        r_tx   <= {r_tx[DATA_WIDE-2:0], 1'b0};
                    end
                end
                ST_TRAIL: begin
                    r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
                    if (w_tick) begin
                        r_done     <= 1'b1;
                        r_rx_data  <= r_rx;
                        r_mosi     <= 1'b0;
                        r_edge_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
//   Directed frames for spi_shift_engine. The stimulus pushes one expectation
//   per frame into a queue before pulsing start_i. A negedge monitor acts as
//   the SPI slave: it drives MISO from the expected slave word and captures
//   MOSI. On each done_o it pops the expectation and checks rx_data_o, busy
//   length, SCLK edge count and the captured MOSI word. It also checks pin
//   values during reset and the cs_n-high gap between back-to-back frames.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

    logic        pclk_i = 1'b0;
    logic        prstn_i;
    logic        start_i;
    logic [31:0] tx_data_i;
    logic [4:0]  len_i;
    logic        cpol_i;
    logic        cpha_i;
    logic [7:0]  clk_div_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rx_data_o;
    logic        spi_sclk_o;
    logic        spi_cs_n_o;
    logic        spi_mosi_o;
    logic        spi_miso_i;

    logic        slv_miso = 1'b0;
    logic        ext_loop = 1'b0;

    assign spi_miso_i = ext_loop ? spi_mosi_o : slv_miso;

    spi_shift_engine #(
        .DATA_WIDE (32),
        .DIV_WIDE  (8),
        .LEN_WIDE  (5)
    ) dut (
        .pclk_i     (pclk_i),
        .prstn_i    (prstn_i),
        .start_i    (start_i),
        .tx_data_i  (tx_data_i),
        .len_i      (len_i),
        .cpol_i     (cpol_i),
        .cpha_i     (cpha_i),
        .clk_div_i  (clk_div_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .rx_data_o  (rx_data_o),
        .spi_sclk_o (spi_sclk_o),
        .spi_cs_n_o (spi_cs_n_o),
        .spi_mosi_o (spi_mosi_o),
        .spi_miso_i (spi_miso_i)
    );

    always #5 pclk_i = ~pclk_i;

    typedef struct {
        logic [31:0] rx;
        logic [31:0] mosi;
        int          busy;
        int          len;
        logic        cpol;
        logic        cpha;
        logic [31:0] sword;
        logic        ext;
        int          gap;
    } exp_t;

    exp_t sb[$];

    int   n_assert = 0;
    int   n_fail   = 0;
    logic tb_end   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / slave model
    exp_t        cur;
    exp_t        e;
    int          busy_cnt  = 0;
    int          gap_cnt   = 0;
    int          tog       = 0;
    int          idx       = 0;
    logic [31:0] slv_mosi  = '0;
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic        in_rst    = 1'b0;
    logic        leading;

    always @(negedge pclk_i) begin
        if (tb_end) begin
            chk("queue_empty", sb.size(), 0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
            $finish;
        end else if (!prstn_i) begin
            if (!in_rst) begin
                chk("reset_pins", {27'd0, busy_o, done_o, spi_cs_n_o, spi_sclk_o, spi_mosi_o}, 32'b00100);
                chk("reset_rx", rx_data_o, 32'h0);
            end
            in_rst    = 1'b1;
            sb.delete();
            busy_cnt  = 0;
            gap_cnt   = 0;
            tog       = 0;
            slv_miso  = 1'b0;
            ext_loop  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = 1'b0;
        end else begin
            in_rst = 1'b0;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                chk("done_has_expect", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rx_data", rx_data_o, e.rx);
                    chk("busy_len", busy_cnt, e.busy);
                    chk("sclk_edges", tog, 2 * (e.len + 1));
                    chk("mosi_word", slv_mosi, e.mosi);
                end
                busy_cnt = 0;
                gap_cnt  = 0;
            end
            if (spi_cs_n_o) gap_cnt++;
            if (prev_cs && !spi_cs_n_o) begin
                if (sb.size() != 0) cur = sb[0];
                else cur.gap = -1;
                if (cur.gap >= 0) chk("cs_gap", gap_cnt, cur.gap);
                chk("sclk_idle", {31'd0, spi_sclk_o}, {31'd0, cur.cpol});
                tog      = 0;
                slv_mosi = '0;
                ext_loop = cur.ext;
                if (!cur.cpha) begin
                    slv_miso = cur.sword[cur.len];
                    idx      = cur.len - 1;
                end else begin
                    slv_miso = 1'b0;
                    idx      = cur.len;
                end
            end else if (!spi_cs_n_o && spi_sclk_o != prev_sclk) begin
                tog++;
                leading = ((tog % 2) == 1);
                if (leading != cur.cpha) begin
                    slv_mosi = {slv_mosi[30:0], prev_mosi};
                end else if (idx >= 0) begin
                    slv_miso = cur.sword[idx];
                    idx--;
                end
            end
            prev_cs   = spi_cs_n_o;
            prev_sclk = spi_sclk_o;
            prev_mosi = spi_mosi_o;
        end
    end

    task automatic send(input logic [31:0] tx, input int len, input logic cpol, input logic cpha,
                        input int div, input logic [31:0] sword, input logic ext,
                        input logic [31:0] exp_rx, input logic [31:0] exp_mosi,
                        input int exp_busy, input int gap);
        exp_t x;
        x.rx = exp_rx; x.mosi = exp_mosi; x.busy = exp_busy; x.len = len;
        x.cpol = cpol; x.cpha = cpha; x.sword = sword; x.ext = ext; x.gap = gap;
        sb.push_back(x);
        tx_data_i = tx;
        len_i     = 5'(len);
        cpol_i    = cpol;
        cpha_i    = cpha;
        clk_div_i = 8'(div);
        start_i   = 1'b1;
        @(posedge pclk_i);
        #1;
        start_i   = 1'b0;
        // Scramble inputs: the engine must run on the latched copies.
        tx_data_i = ~tx;
        len_i     = ~len_i;
        cpol_i    = ~cpol;
        cpha_i    = ~cpha;
        clk_div_i = ~clk_div_i;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge pclk_i);
            #1;
            if (done_o) break;
        end
    endtask

    logic [31:0] lb_rx;

    initial begin
`ifdef SPI_SHIFT_LOOPBACK_EN
        lb_rx = 32'h3C;
`else
        lb_rx = 32'h0;
`endif
        prstn_i   = 1'b0;
        start_i   = 1'b0;
        tx_data_i = '0;
        len_i     = '0;
        cpol_i    = 1'b0;
        cpha_i    = 1'b0;
        clk_div_i = '0;
        repeat (3) @(posedge pclk_i);
        #1 prstn_i = 1'b1;
        repeat (2) @(posedge pclk_i);
        #1;

        // Mode 0, 8 bits, div 0, MISO looped to MOSI: busy 18
        send(32'hA5, 7, 1'b0, 1'b0, 0, 32'h0, 1'b1, 32'hA5, 32'hA5, 18, -1);
        wait_done(100);
        repeat (3) @(posedge pclk_i); #1;

        // Mode 3, 32 bits, div 3: busy (64+2)*4 = 264
        send(32'h12345678, 31, 1'b1, 1'b1, 3, 32'hCAFEBABE, 1'b0, 32'hCAFEBABE, 32'h12345678, 264, -1);
        wait_done(400);
        repeat (3) @(posedge pclk_i); #1;

        // Mode 0, 8 bits, div 1 (busy 36), with an ignored mid-frame start
        send(32'h3B, 7, 1'b0, 1'b0, 1, 32'h96, 1'b0, 32'h96, 32'h3B, 36, -1);
        repeat (9) @(posedge pclk_i); #1;
        tx_data_i = 32'hFFFF_FFFF;
        start_i   = 1'b1;
        @(posedge pclk_i); #1;
        start_i   = 1'b0;
        wait_done(100);
        // Start in the done cycle: mode 1, 4 bits, div 0, busy 10, gap 1
        send(32'h9, 3, 1'b0, 1'b1, 0, 32'h6, 1'b0, 32'h6, 32'h9, 10, 1);
        wait_done(100);
        repeat (3) @(posedge pclk_i); #1;

        // Mode 1 frame aborted by reset mid-SHIFT
        send(32'h55, 7, 1'b0, 1'b1, 1, 32'hFF, 1'b0, 32'h0, 32'h0, 0, -1);
        repeat (10) @(posedge pclk_i);
        #2 prstn_i = 1'b0;
        repeat (2) @(posedge pclk_i);
        #1 prstn_i = 1'b1;
        repeat (3) @(posedge pclk_i); #1;

        // Mode 2, 1 bit, div 2: busy 4*3 = 12, MISO 0
        send(32'h1, 0, 1'b1, 1'b0, 2, 32'h0, 1'b0, 32'h0, 32'h1, 12, -1);
        wait_done(100);
        repeat (3) @(posedge pclk_i); #1;

        // Mode 0, 1 bit, maximum divider: busy 4*256 = 1024
        send(32'h0, 0, 1'b0, 1'b0, 255, 32'h1, 1'b0, 32'h1, 32'h0, 1024, -1);
        wait_done(1200);
        repeat (3) @(posedge pclk_i); #1;

        // MISO held at 0: loopback build returns tx, normal build returns 0
        send(32'h3C, 7, 1'b0, 1'b0, 0, 32'h0, 1'b0, lb_rx, 32'h3C, 18, -1);
        wait_done(100);
        repeat (3) @(posedge pclk_i); #1;

        tb_end = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
- SPI master shift engine downstream of spi_apb_if. It consumes the control and data values that spi_apb_if holds in its registers: start, TX word, mode, divider and length.
- Generates spi_sclk_o, spi_cs_n_o and spi_mosi_o, and samples spi_miso_i. Returns the RX word, a busy flag and a done pulse to the register file.
- Supports all four CPOL/CPHA modes, a programmable SCLK divider and a programmable frame length of 1..DATA_WIDE bits, transmitted MSB-first.

Parameters:
- DATA_WIDE, 32, maximum frame length in bits and width of the TX/RX words.
- DIV_WIDE, 8, width of the clock divider input.
- LEN_WIDE, 5, width of len_i; must equal $clog2(DATA_WIDE).

Ports:
- pclk_i  input  1  system clock.
- prstn_i  input  1  reset.
- start_i  input  1  single-cycle transfer request; accepted only when busy_o=0.
- tx_data_i  input  DATA_WIDE  transmit word; bits [len_i:0] are sent.
- len_i  input  LEN_WIDE  frame length minus 1 (N = len_i+1).
- cpol_i  input  1  SCLK idle level.
- cpha_i  input  1  0: sample on the leading edge; 1: sample on the trailing edge.
- clk_div_i  input  DIV_WIDE  half-period H = clk_div_i+1 pclk cycles.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle completion pulse.
- rx_data_o  output  DATA_WIDE  received word, right-aligned, upper bits zero.
- spi_sclk_o  output  1  serial clock.
- spi_cs_n_o  output  1  chip select, active low.
- spi_mosi_o  output  1  serial data out.
- spi_miso_i  input  1  serial data in.

Behaviour:
- Clock and reset (already decided): one clock, pclk_i; reset prstn_i is asynchronous and active-low.
- Reset values: busy_o=0, done_o=0, rx_data_o=0, spi_sclk_o=0, spi_cs_n_o=1, spi_mosi_o=0; FSM in IDLE; divider and bit counters 0.
- Reset asserted mid-transfer aborts immediately to these values. No done_o pulse is generated and rx_data_o is not updated.
- FSM states:
  - IDLE: spi_sclk_o <= cpol_i, updated every cycle.
  - On start_i: latch tx_data_i, len_i, cpol_i, cpha_i and clk_div_i, then go to LEAD. Inputs changing mid-transfer have no effect.
  - LEAD (H cycles): cs_n=0; SCLK held at CPOL; if CPHA=0, MOSI = bit N-1.
  - SHIFT (2N*H cycles): SCLK toggles every H cycles, giving 2N edges.
    - CPHA=0: sample MISO on odd (leading) edges; drive the next bit on even (trailing) edges, except the last.
    - CPHA=1: drive on leading edges; sample on trailing edges.
  - TRAIL (H cycles): SCLK at CPOL; cs_n still 0.
  - After TRAIL: return to IDLE; cs_n=1, busy_o=0, done_o=1 for one cycle, and rx_data_o is loaded in the same cycle.
- Timing:
  - busy_o rises in the cycle after start_i is sampled and stays high exactly (2N+2)*H cycles.
  - rx_data_o holds its value until the next done_o.
- MISO is sampled on the pclk edge that produces the SCLK sampling edge (no synchroniser). RX shifts in MSB-first, so the final rx_data_o = {zeros, rx[N-1:0]}.
- Boundary conditions:
  - start_i while busy_o=1 is ignored.
  - start_i in the done_o cycle is accepted, giving back-to-back frames with one cs_n-high cycle between them.
  - len_i = 0 produces a 1-bit frame.
  - clk_div_i = 0 gives SCLK = pclk/2.
  - clk_div_i at maximum gives H = 2^DIV_WIDE with no overflow, because the counter is DIV_WIDE+1 bits or compares against clk_div_i.

Optional Feature:
- Macro: SPI_SHIFT_LOOPBACK_EN.
- When defined: the RX shifter samples the internal MOSI bit instead of spi_miso_i, so every frame returns rx_data_o = tx_data_i[len_i:0]. spi_miso_i is ignored; all pins still toggle normally.
- When undefined: spi_miso_i is sampled as described in Behaviour.

Test Plan:
- Mode 0, len=7, div=0, tx=0xA5, MISO tied to MOSI externally:
  - busy_o high for 18 cycles; 8 SCLK pulses; MOSI sequence 1,0,1,0,0,1,0,1.
  - done_o pulses once; rx_data_o=0x000000A5.
- Mode 3, len=31, div=3, tx=0x12345678, slave model returning 0xCAFEBABE:
  - SCLK idles high, half-period 4 cycles; busy_o high for 264 cycles.
  - rx_data_o=0xCAFEBABE.
- start_i pulsed again 10 cycles into a frame, and start_i in the done_o cycle:
  - Mid-frame start is ignored (single frame, unchanged busy length).
  - done-cycle start begins the second frame with cs_n high for exactly 1 cycle.
- prstn_i low mid-SHIFT of a mode 1 frame:
  - Immediately cs_n=1, sclk=0, busy_o=0, done_o stays 0, rx_data_o keeps its prior value of 0 after reset.
- len=0, mode 2, tx bit0=1, MISO=0:
  - One SCLK pulse; busy_o high 4*H cycles; rx_data_o=0.
- With SPI_SHIFT_LOOPBACK_EN, spi_miso_i forced to 0, tx=0x3C, len=7:
  - rx_data_o=0x3C.
